// File: rtl/spike_pkg.sv
// Shared defaults and types for the spike event logger.
// The timestamp type is sized for the default configuration.
package spike_pkg;
    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 8;

    typedef logic [TS_WIDTH_DEF-1:0] ts_t;
endpackage

// File: rtl/spike_event_logger_if.sv
// Output stream of logged spike timestamps: valid/ready handshake plus head data.
interface spike_event_logger_if
    import spike_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF
);
    logic                out_valid;
    logic                out_ready;
    logic [TS_WIDTH-1:0] out_timestamp;

    modport master (output out_valid, output out_timestamp, input out_ready);
    modport slave  (input out_valid, input out_timestamp, output out_ready);
endinterface

// File: rtl/spike_fifo.sv
// Single-clock FIFO holding spike timestamps.
// A push into a full FIFO is accepted only when a pop frees the head slot on the same edge.
module spike_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_en, pop_en;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_en   = pop && !empty;
    assign push_en  = push && (!full || pop_en);
    // Empty FIFO presents zero rather than stale storage
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/spike_event_logger.sv
// Timestamps each spike_in cycle with a free-running counter and queues it for a consumer.
// Events arriving while the queue is full are counted in a saturating drop counter.
module spike_event_logger
    import spike_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spike_in,
    input  logic                     clear_overflow,
    spike_event_logger_if.master     out_bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_count
);
    logic [TS_WIDTH-1:0] ts;
    logic                full, empty, drop;

    spike_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (spike_in),
        .push_data (ts),
        .pop       (out_bus.out_ready),
        .pop_data  (out_bus.out_timestamp),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign out_bus.out_valid = !empty;
    assign drop = spike_in && full && !out_bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    // A drop on the same edge as a clear restarts the count at one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow)     drop_count <= CNT_WIDTH'(1);
            else if (&drop_count)   drop_count <= drop_count;
            else                    drop_count <= drop_count + CNT_WIDTH'(1);
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_spike_event_logger.sv
// Randomized and directed bench for spike_event_logger against a queue-based reference model.
module tb_spike_event_logger;
    import spike_pkg::*;

    localparam int DEPTH  = 8;
    localparam int CNTMAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spike_in = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;

    spike_event_logger_if #(.TS_WIDTH(16)) bus ();

    spike_event_logger #(.TS_WIDTH(16), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .spike_in       (spike_in),
        .clear_overflow (clear_overflow),
        .out_bus        (bus),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ts_t  m_q[$];
    ts_t  m_ts;
    bit   m_ovf;
    int   m_dc;
    ts_t  obs[$];
    ts_t  e_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_valid"}, 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk({pfx, "_count"}, 32'(fifo_count), 32'(m_q.size()));
        chk({pfx, "_ts"}, 32'(bus.out_timestamp), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk({pfx, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({pfx, "_drops"}, 32'(drop_count), 32'(m_dc));
    endtask

    // Reference: queue of timestamps with bounded capacity and a saturating drop tally
    task automatic model_edge(input bit sp, input bit rdy, input bit clr);
        bit pop, full, drop;
        pop  = rdy && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        drop = sp && full && !pop;
        if (pop) void'(m_q.pop_front());
        if (sp && !drop) m_q.push_back(m_ts);
        if (drop) begin
            m_ovf = 1'b1;
            m_dc  = clr ? 1 : ((m_dc == CNTMAX) ? CNTMAX : m_dc + 1);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
        m_ts = m_ts + 16'd1;
    endtask

    // Called at a negedge; checks state, records handshakes, advances one edge
    task automatic step(input bit sp, input bit rdy, input bit clr);
        spike_in          = sp;
        bus.out_ready     = rdy;
        clear_overflow    = clr;
        check_outputs("cyc");
        if (bus.out_valid && rdy) obs.push_back(bus.out_timestamp);
        @(posedge clk);
        model_edge(sp, rdy, clr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        spike_in       = 1'b0;
        bus.out_ready  = 1'b0;
        clear_overflow = 1'b0;
        repeat (n) begin
            @(posedge clk);
            m_ts = m_ts + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        spike_in       = 1'b0;
        bus.out_ready  = 1'b0;
        clear_overflow = 1'b0;
        reset = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
        m_ts  = '0;
        check_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        obs.delete();
    endtask

    task automatic chk_obs(input string tag);
        chk({tag, "_n"}, 32'(obs.size()), 32'(e_q.size()));
        for (int i = 0; i < e_q.size(); i++)
            chk(tag, (i < obs.size()) ? 32'(obs[i]) : 32'hdead_beef, 32'(e_q[i]));
        obs.delete();
        e_q.delete();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // single event at ts 2 with a ready consumer
        step(0, 1, 0); step(0, 1, 0); step(1, 1, 0);
        repeat (3) step(0, 1, 0);
        chk("r32_count", 32'(fifo_count), 32'd0);
        e_q.push_back(16'd2);
        chk_obs("r32_ts");

        // burst of three from ts 10, held then drained
        do_reset();
        repeat (10) step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        chk("r33_count", 32'(fifo_count), 32'd3);
        repeat (4) step(0, 1, 0);
        for (int i = 10; i < 13; i++) e_q.push_back(16'(i));
        chk_obs("r33_ts");

        // ten spikes into an eight-deep queue
        do_reset();
        repeat (10) step(1, 0, 0);
        chk("r34_count", 32'(fifo_count), 32'd8);
        chk("r34_ovf", 32'(overflow), 32'd1);
        chk("r34_drops", 32'(drop_count), 32'd2);
        repeat (9) step(0, 1, 0);
        for (int i = 0; i < 8; i++) e_q.push_back(16'(i));
        chk_obs("r34_ts");

        // push and pop together while full
        do_reset();
        repeat (9) step(1, 0, 0);
        step(1, 1, 0);
        chk("r35_count", 32'(fifo_count), 32'd8);
        chk("r35_ovf", 32'(overflow), 32'd1);
        chk("r35_drops", 32'(drop_count), 32'd1);
        obs.delete();
        repeat (9) step(0, 1, 0);
        for (int i = 1; i < 8; i++) e_q.push_back(16'(i));
        e_q.push_back(16'd9);
        chk_obs("r35_ts");

        // timestamp wrap
        do_reset();
        idle(16'hFFFE);
        repeat (3) step(1, 0, 0);
        repeat (4) step(0, 1, 0);
        e_q.push_back(16'hFFFE); e_q.push_back(16'hFFFF); e_q.push_back(16'h0000);
        chk_obs("r36_ts");

        // reset mid-operation, then clear racing a drop, then saturation
        do_reset();
        repeat (5) step(1, 0, 0);
        chk("r37_pre", 32'(fifo_count), 32'd5);
        do_reset();
        chk("r37_valid", 32'(bus.out_valid), 32'd0);
        chk("r37_count", 32'(fifo_count), 32'd0);
        repeat (11) step(1, 0, 0);
        chk("r37_drops3", 32'(drop_count), 32'd3);
        step(1, 0, 1);
        chk("r37_clrdrop", 32'(drop_count), 32'd1);
        chk("r37_clrovf", 32'(overflow), 32'd1);
        step(0, 0, 1);
        chk("r37_clr", 32'(drop_count), 32'd0);
        repeat (300) step(1, 0, 0);
        chk("sat_drops", 32'(drop_count), 32'd255);

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(99) < 60), ($urandom_range(99) < 45), ($urandom_range(99) < 4));
        obs.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_event_logger.md
SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

Interface
REQ-001 The block SHALL have parameter TS_WIDTH, default 16, timestamp width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, event FIFO depth in entries (power of two, >= 2).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, drop-counter width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spike_in  input  1  spike from the upstream neuron's spike_out; each high cycle is one event.
REQ-007 out_valid  output  1  head FIFO entry is available.
REQ-008 out_ready  input  1  consumer accepts head entry this cycle.
REQ-009 out_timestamp  output  TS_WIDTH  timestamp of head entry.
REQ-010 fifo_count  output  clog2(DEPTH)+1  entries currently held.
REQ-011 overflow  output  1  sticky: at least one event dropped since last clear.
REQ-012 drop_count  output  CNT_WIDTH  number of dropped events, saturating.
REQ-013 clear_overflow  input  1  synchronous clear of overflow and drop_count.

Function
REQ-014 A free-running TS_WIDTH counter SHALL increment every cycle after reset, wrapping from all-ones to 0.
REQ-015 A push SHALL occur on any rising edge with spike_in=1, storing the timestamp value present before that edge's increment.
REQ-016 Consecutive high cycles of spike_in SHALL produce one push per cycle with consecutive timestamps.
REQ-017 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal (fifo_count != 0); out_timestamp SHALL show the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-019 Latency: an event pushed at edge N into an empty FIFO SHALL make out_valid=1 in the cycle after edge N.
REQ-020 Data SHALL leave in push order (FIFO); pointers SHALL wrap modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged, including when full.
REQ-022 Push when full with no pop SHALL drop the event, set overflow=1, and increment drop_count, saturating at all-ones.
REQ-023 Pop when empty SHALL not occur (out_valid=0); out_ready is ignored when empty.
REQ-024 clear_overflow=1 SHALL set overflow=0 and drop_count=0 at the next edge; a drop on the same edge wins (overflow=1, drop_count=1).
REQ-025 out_timestamp SHALL be 0 when empty.

Reset
REQ-026 Asserting reset SHALL immediately force timestamp counter=0, pointers=0, fifo_count=0, out_valid=0, out_timestamp=0, overflow=0, drop_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored events; no pop or push SHALL be reported on the edge of deassertion.
REQ-028 The first edge after reset deasserts SHALL sample spike_in with timestamp 0.

Structure
REQ-029 A shared package spike_pkg SHALL hold the TS_WIDTH, DEPTH and CNT_WIDTH defaults and a timestamp type.
REQ-030 The storage and pointers SHALL be one sub-module, spike_fifo (synchronous, single clock, push/pop/full/empty/count).
REQ-031 The timestamp counter, drop logic and overflow flag SHALL live in the top level.

Verification
REQ-032 Reset, then spike_in=1 for one cycle at timestamp 2, out_ready=1 -> exactly one handshake with out_timestamp=2, fifo_count returns to 0.
REQ-033 spike_in=1 for 3 consecutive cycles from ts 10, out_ready=0 -> fifo_count=3; then out_ready=1 -> timestamps 10,11,12 in order.
REQ-034 out_ready=0, 10 spike cycles, DEPTH=8 -> fifo_count=8, overflow=1, drop_count=2, stored timestamps are the first 8.
REQ-035 FIFO full, spike_in=1 and out_ready=1 same cycle -> fifo_count stays 8, overflow unchanged, new timestamp at tail.
REQ-036 Run timestamp to 0xFFFE, spike for 3 cycles -> entries 0xFFFE, 0xFFFF, 0x0000.
REQ-037 Assert reset with 5 entries stored, release -> out_valid=0, fifo_count=0, overflow=0 immediately; clear_overflow with concurrent drop -> drop_count=1.
